// File: rtl/rename_table_int.sv
// rename_table_int: integer register alias table with branch checkpoints.
// Renames one group per cycle against the map, allocating destinations from the free list.
module rename_table_int #(
   parameter int RENAME_WIDTH   = 2,
   parameter int ARF_INDEX_SIZE = 5,
   parameter int PRF_INDEX_SIZE = 6,
   parameter int CP_SIZE        = 4,
   parameter int CP_INDEX_SIZE  = 2
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic [RENAME_WIDTH-1:0]                        in_valid,
   input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]    in_rs1,
   input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]    in_rs2,
   input  logic [RENAME_WIDTH-1:0][ARF_INDEX_SIZE-1:0]    in_rd,
   input  logic [RENAME_WIDTH-1:0]                        in_rd_valid,
   input  logic                                           in_check,
   input  logic [CP_INDEX_SIZE-1:0]                       in_check_idx,
   output logic                                           in_ready,
   input  logic                                           recover,
   input  logic [CP_INDEX_SIZE-1:0]                       recover_idx,
   output logic [RENAME_WIDTH-1:0]                        prf_req,
   input  logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0]    prf_out,
   input  logic                                           allocatable,
   output logic [RENAME_WIDTH-1:0]                        out_valid,
   output logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0]    out_prs1,
   output logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0]    out_prs2,
   output logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0]    out_prd,
   output logic [RENAME_WIDTH-1:0][PRF_INDEX_SIZE-1:0]    out_prd_old
);
   localparam int W  = RENAME_WIDTH;
   localparam int A  = ARF_INDEX_SIZE;
   localparam int P  = PRF_INDEX_SIZE;
   localparam int NA = 1 << A;
   localparam int KW = (W > 1) ? $clog2(W) : 1;

   logic [P-1:0] map_q [NA];
   logic [P-1:0] map_d [NA];
   logic [P-1:0] cp_q [CP_SIZE][NA];
   logic s1_full_q, s1_check_q;
   logic [CP_INDEX_SIZE-1:0] s1_idx_q;
   logic [W-1:0] s1_valid_q, s1_rdv_q, in_mask, s1_mask;
   logic [W-1:0][A-1:0] s1_rs1_q, s1_rs2_q, s1_rd_q;
   logic [W-1:0][P-1:0] prs1_d, prs2_d, prd_d, old_d;
   logic stall, done, accept;

   always_comb begin
      for (int i = 0; i < W; i++) begin
         in_mask[i] = in_valid[i] & in_rd_valid[i] & (in_rd[i] != '0);
         s1_mask[i] = s1_valid_q[i] & s1_rdv_q[i] & (s1_rd_q[i] != '0);
      end
   end

   // a failed grant holds S1 and re-requests from its mask until the free list succeeds
   assign stall    = s1_full_q & (|s1_mask) & ~allocatable;
   assign in_ready = ~recover & ~stall;
   assign accept   = in_ready & (|in_valid);
   assign done     = s1_full_q & ~recover & ~stall;
   assign prf_req  = recover ? '0 : stall ? s1_mask : accept ? in_mask : '0;

   // walking the group in slot order over a working copy gives the intra-group bypass
   always_comb begin
      logic [KW-1:0] k;
      k = '0;
      map_d = map_q;
      for (int i = 0; i < W; i++) begin
         prs1_d[i] = map_d[s1_rs1_q[i]];
         prs2_d[i] = map_d[s1_rs2_q[i]];
         old_d[i]  = s1_mask[i] ? map_d[s1_rd_q[i]] : '0;
         prd_d[i]  = s1_mask[i] ? prf_out[k] : '0;
         if (s1_mask[i]) begin
            map_d[s1_rd_q[i]] = prf_out[k];
            k = k + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NA; r++) begin
            map_q[r] <= '0;
            for (int c = 0; c < CP_SIZE; c++) cp_q[c][r] <= '0;
         end
         s1_full_q   <= 1'b0;
         s1_check_q  <= 1'b0;
         s1_idx_q    <= '0;
         s1_valid_q  <= '0;
         s1_rdv_q    <= '0;
         s1_rs1_q    <= '0;
         s1_rs2_q    <= '0;
         s1_rd_q     <= '0;
         out_valid   <= '0;
         out_prs1    <= '0;
         out_prs2    <= '0;
         out_prd     <= '0;
         out_prd_old <= '0;
      end else begin
         if (recover) map_q <= cp_q[recover_idx];
         else if (done) map_q <= map_d;
         if (done & s1_check_q) cp_q[s1_idx_q] <= map_d;
         if (recover) s1_full_q <= 1'b0;
         else if (!stall) begin
            s1_full_q <= accept;
            if (accept) begin
               s1_valid_q <= in_valid;
               s1_rdv_q   <= in_rd_valid;
               s1_rs1_q   <= in_rs1;
               s1_rs2_q   <= in_rs2;
               s1_rd_q    <= in_rd;
               s1_check_q <= in_check;
               s1_idx_q   <= in_check_idx;
            end
         end
         out_valid   <= done ? s1_valid_q : '0;
         out_prs1    <= prs1_d;
         out_prs2    <= prs2_d;
         out_prd     <= prd_d;
         out_prd_old <= old_d;
      end
   end
endmodule

// File: tb/tb_rename_table_int.sv
// tb_rename_table_int: randomized and directed checks of the rename table against a group-level model.
module tb_rename_table_int;
   logic clock = 1'b0;
   logic reset;
   logic [1:0] in_valid, in_rd_valid, prf_req, out_valid, in_check_idx, recover_idx;
   logic [1:0][4:0] in_rs1, in_rs2, in_rd;
   logic in_check, recover, allocatable, in_ready;
   logic [1:0][5:0] prf_out, out_prs1, out_prs2, out_prd, out_prd_old;
   int checks = 0, passes = 0;

   logic [5:0] m [32];
   logic [5:0] mcp [4][32];
   logic [1:0] gv, gw, ev, req;
   logic [1:0][4:0] g1, g2, gd;
   logic gchk;
   logic [1:0] gidx;
   logic [1:0][5:0] e_prs1, e_prs2, e_prd, e_old;

   always #5 clock = ~clock;

   rename_table_int dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd(in_rd), .in_rd_valid(in_rd_valid), .in_check(in_check), .in_check_idx(in_check_idx),
      .in_ready(in_ready), .recover(recover), .recover_idx(recover_idx), .prf_req(prf_req),
      .prf_out(prf_out), .allocatable(allocatable), .out_valid(out_valid), .out_prs1(out_prs1),
      .out_prs2(out_prs2), .out_prd(out_prd), .out_prd_old(out_prd_old)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      in_valid = '0; in_rd_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_check = 1'b0; in_check_idx = '0;
   endtask

   task automatic put(input logic [1:0] v, input logic [1:0] w, input logic [1:0][4:0] a,
                      input logic [1:0][4:0] b, input logic [1:0][4:0] d, input logic c,
                      input logic [1:0] ci);
      in_valid = v; in_rd_valid = w; in_rs1 = a; in_rs2 = b; in_rd = d;
      in_check = c; in_check_idx = ci;
      gv = v; gw = w; g1 = a; g2 = b; gd = d; gchk = c; gidx = ci;
      for (int i = 0; i < 2; i++) req[i] = v[i] & w[i] & (d[i] != 5'd0);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m[r] = 6'd0;
         for (int c = 0; c < 4; c++) mcp[c][r] = 6'd0;
      end
   endtask

   task automatic model_recover(input logic [1:0] idx);
      for (int r = 0; r < 32; r++) m[r] = mcp[idx][r];
   endtask

   // k-th renaming slot gets grant k; a source sees the youngest older in-group writer
   task automatic model(input logic [1:0][5:0] g);
      bit ren [2];
      int n;
      n = 0;
      ev = gv;
      for (int i = 0; i < 2; i++) begin
         ren[i] = gv[i] && gw[i] && gd[i] != 5'd0;
         e_prd[i] = ren[i] ? g[n] : 6'd0;
         if (ren[i]) n++;
      end
      for (int i = 0; i < 2; i++) begin
         e_prs1[i] = m[g1[i]];
         e_prs2[i] = m[g2[i]];
         e_old[i] = ren[i] ? m[gd[i]] : 6'd0;
         for (int j = 0; j < i; j++) if (ren[j]) begin
            if (gd[j] == g1[i]) e_prs1[i] = e_prd[j];
            if (gd[j] == g2[i]) e_prs2[i] = e_prd[j];
            if (ren[i] && gd[j] == gd[i]) e_old[i] = e_prd[j];
         end
      end
      for (int i = 0; i < 2; i++) if (ren[i]) m[gd[i]] = e_prd[i];
      if (gchk) for (int r = 0; r < 32; r++) mcp[gidx][r] = m[r];
   endtask

   task automatic run_group(input logic [1:0] v, input logic [1:0] w, input logic [1:0][4:0] a,
                            input logic [1:0][4:0] b, input logic [1:0][4:0] d, input logic c,
                            input logic [1:0] ci, input logic [1:0][5:0] g);
      put(v, w, a, b, d, c, ci);
      tick();
      idle();
      allocatable = 1'b1;
      prf_out = g;
      model(g);
      tick();
      allocatable = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; recover = 1'b0; recover_idx = '0; allocatable = 1'b0; prf_out = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({out_valid, out_prs1, out_prs2, out_prd, out_prd_old} !== 50'd0)
         $display("FAIL reset_outs got %h exp 0", {out_valid, out_prs1, out_prs2, out_prd, out_prd_old});
      else passes++;
      checks++;
      if ({in_ready, prf_req} !== 3'b100) $display("FAIL reset_ready got %b exp 100", {in_ready, prf_req});
      else passes++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      put(2'b11, 2'b11, {5'd1, 5'd2}, {5'd1, 5'd3}, {5'd4, 5'd1}, 1'b0, 2'd0);
      #1;
      checks++;
      if ({in_ready, prf_req} !== 3'b111) $display("FAIL basic_req got %b exp 111", {in_ready, prf_req});
      else passes++;
      tick();
      idle();
      allocatable = 1'b1;
      prf_out = {6'd2, 6'd1};
      model(prf_out);
      #1;
      checks++;
      if (out_valid !== 2'b00) $display("FAIL basic_early got %b exp 00", out_valid);
      else passes++;
      tick();
      allocatable = 1'b0;
      checks++;
      if (out_valid !== 2'b11) $display("FAIL basic_valid got %b exp 11", out_valid);
      else passes++;
      checks++;
      if ({out_prd, out_prd_old, out_prs1[1], out_prs2[1]} !== {6'd2, 6'd1, 12'd0, 6'd1, 6'd1})
         $display("FAIL basic_const got %h exp %h", {out_prd, out_prd_old, out_prs1[1], out_prs2[1]},
                  {6'd2, 6'd1, 12'd0, 6'd1, 6'd1});
      else passes++;
      for (int i = 0; i < 2; i++) if (ev[i]) begin
         checks++;
         if ({out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]} !== {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]})
            $display("FAIL basic_slot%0d got %h exp %h", i, {out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]},
                     {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]});
         else passes++;
      end
      tick();
      checks++;
      if (out_valid !== 2'b00) $display("FAIL basic_pulse got %b exp 00", out_valid);
      else passes++;
   endtask

   task automatic test_same_rd();
      logic [5:0] prev;
      prev = m[5];
      run_group(2'b11, 2'b11, {5'd5, 5'd4}, {5'd0, 5'd1}, {5'd5, 5'd5}, 1'b0, 2'd0, {6'd4, 6'd3});
      checks++;
      if ({out_prd_old[1], out_prd_old[0], out_prs1[1]} !== {6'd3, prev, 6'd3})
         $display("FAIL samerd_old got %h exp %h", {out_prd_old[1], out_prd_old[0], out_prs1[1]}, {6'd3, prev, 6'd3});
      else passes++;
      for (int i = 0; i < 2; i++) if (ev[i]) begin
         checks++;
         if ({out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]} !== {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]})
            $display("FAIL samerd_slot%0d got %h exp %h", i, {out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]},
                     {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]});
         else passes++;
      end
      run_group(2'b01, 2'b00, {5'd0, 5'd5}, {5'd0, 5'd4}, {5'd0, 5'd0}, 1'b0, 2'd0, {6'd0, 6'd0});
      checks++;
      if ({out_valid, out_prs1[0], out_prs2[0]} !== {2'b01, 6'd4, m[4]})
         $display("FAIL samerd_map got %h exp %h", {out_valid, out_prs1[0], out_prs2[0]}, {2'b01, 6'd4, m[4]});
      else passes++;
   endtask

   task automatic test_x0();
      put(2'b11, 2'b11, {5'd0, 5'd0}, {5'd7, 5'd1}, {5'd7, 5'd0}, 1'b0, 2'd0);
      #1;
      checks++;
      if (prf_req !== 2'b10) $display("FAIL x0_req got %b exp 10", prf_req);
      else passes++;
      tick();
      idle();
      allocatable = 1'b1;
      prf_out = {6'd0, 6'd9};
      model(prf_out);
      tick();
      allocatable = 1'b0;
      checks++;
      if ({out_prd[0], out_prd[1], out_prs1[0], out_prs1[1]} !== {6'd0, 6'd9, 6'd0, 6'd0})
         $display("FAIL x0_const got %h exp %h", {out_prd[0], out_prd[1], out_prs1[0], out_prs1[1]},
                  {6'd0, 6'd9, 6'd0, 6'd0});
      else passes++;
      for (int i = 0; i < 2; i++) if (ev[i]) begin
         checks++;
         if ({out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]} !== {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]})
            $display("FAIL x0_slot%0d got %h exp %h", i, {out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]},
                     {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]});
         else passes++;
      end
   endtask

   task automatic test_stall();
      put(2'b11, 2'b11, {5'd10, 5'd7}, {5'd11, 5'd5}, {5'd11, 5'd10}, 1'b0, 2'd0);
      tick();
      idle();
      allocatable = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if ({in_ready, prf_req} !== 3'b011) $display("FAIL stall%0d_req got %b exp 011", s, {in_ready, prf_req});
         else passes++;
         tick();
         checks++;
         if (out_valid !== 2'b00) $display("FAIL stall%0d_valid got %b exp 00", s, out_valid);
         else passes++;
      end
      allocatable = 1'b1;
      prf_out = {6'd21, 6'd20};
      model(prf_out);
      #1;
      checks++;
      if ({in_ready, prf_req} !== 3'b100) $display("FAIL stall_release got %b exp 100", {in_ready, prf_req});
      else passes++;
      tick();
      allocatable = 1'b0;
      checks++;
      if (out_valid !== 2'b11) $display("FAIL stall_done got %b exp 11", out_valid);
      else passes++;
      for (int i = 0; i < 2; i++) if (ev[i]) begin
         checks++;
         if ({out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]} !== {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]})
            $display("FAIL stall_slot%0d got %h exp %h", i, {out_prs1[i], out_prs2[i], out_prd[i], out_prd_old[i]},
                     {e_prs1[i], e_prs2[i], e_prd[i], e_old[i]});
         else passes++;
      end
      tick();
      checks++;
      if (out_valid !== 2'b00) $display("FAIL stall_pulse got %b exp 00", out_valid);
      else passes++;
   endtask

   task automatic test_checkpoint_recover();
      run_group(2'b01, 2'b01, '0, '0, {5'd0, 5'd12}, 1'b1, 2'd2, {6'd0, 6'd30});
      run_group(2'b01, 2'b01, '0, '0, {5'd0, 5'd12}, 1'b0, 2'd0, {6'd0, 6'd31});
      put(2'b01, 2'b01, '0, '0, {5'd0, 5'd12}, 1'b0, 2'd0);
      tick();
      idle();
      allocatable = 1'b1;
      prf_out = {6'd0, 6'd32};
      recover = 1'b1;
      recover_idx = 2'd2;
      model_recover(2'd2);
      #1;
      checks++;
      if ({in_ready, prf_req} !== 3'b000) $display("FAIL cprec_req got %b exp 000", {in_ready, prf_req});
      else passes++;
      tick();
      recover = 1'b0;
      checks++;
      if (out_valid !== 2'b00) $display("FAIL cprec_valid got %b exp 00", out_valid);
      else passes++;
      run_group(2'b11, 2'b00, {5'd1, 5'd12}, {5'd5, 5'd4}, '0, 1'b0, 2'd0, '0);
      checks++;
      if ({out_valid, out_prs1[0]} !== {2'b11, 6'd30})
         $display("FAIL cprec_map got %h exp %h", {out_valid, out_prs1[0]}, {2'b11, 6'd30});
      else passes++;
      for (int i = 0; i < 2; i++) if (ev[i]) begin
         checks++;
         if ({out_prs1[i], out_prs2[i]} !== {e_prs1[i], e_prs2[i]})
            $display("FAIL cprec_slot%0d got %h exp %h", i, {out_prs1[i], out_prs2[i]}, {e_prs1[i], e_prs2[i]});
         else passes++;
      end
   endtask

   task automatic test_recover_drop();
      put(2'b01, 2'b01, '0, '0, {5'd0, 5'd13}, 1'b1, 2'd1);
      tick();
      idle();
      allocatable = 1'b1;
      prf_out = {6'd0, 6'd40};
      recover = 1'b1;
      recover_idx = 2'd1;
      model_recover(2'd1);
      tick();
      recover = 1'b0;
      checks++;
      if (out_valid !== 2'b00) $display("FAIL drop_valid got %b exp 00", out_valid);
      else passes++;
      run_group(2'b01, 2'b01, '0, '0, {5'd0, 5'd13}, 1'b0, 2'd0, {6'd0, 6'd41});
      recover = 1'b1;
      recover_idx = 2'd1;
      model_recover(2'd1);
      tick();
      recover = 1'b0;
      run_group(2'b01, 2'b00, {5'd0, 5'd13}, '0, '0, 1'b0, 2'd0, '0);
      checks++;
      if (out_prs1[0] !== e_prs1[0] || out_prs1[0] === 6'd40)
         $display("FAIL drop_cp got %h exp %h", out_prs1[0], e_prs1[0]);
      else passes++;
   endtask

   task automatic test_back_to_back();
      put(2'b11, 2'b11, {5'd2, 5'd3}, {5'd4, 5'd2}, {5'd2, 5'd3}, 1'b0, 2'd0);
      tick();
      allocatable = 1'b1;
      prf_out = {6'd51, 6'd50};
      model(prf_out);
      put(2'b11, 2'b01, {5'd3, 5'd2}, {5'd2, 5'd3}, {5'd6, 5'd2}, 1'b0, 2'd0);
      #1;
      checks++;
      if ({in_ready, prf_req} !== 3'b101) $display("FAIL b2b_accept got %b exp 101", {in_ready, prf_req});
      else passes++;
      tick();
      checks++;
      if ({out_valid, out_prd, out_prs1, out_prs2, out_prd_old} !== {ev, e_prd, e_prs1, e_prs2, e_old})
         $display("FAIL b2b_first got %h exp %h", {out_valid, out_prd, out_prs1, out_prs2, out_prd_old},
                  {ev, e_prd, e_prs1, e_prs2, e_old});
      else passes++;
      idle();
      prf_out = {6'd0, 6'd52};
      model(prf_out);
      tick();
      allocatable = 1'b0;
      checks++;
      if ({out_valid, out_prd, out_prs1, out_prs2, out_prd_old} !== {ev, e_prd, e_prs1, e_prs2, e_old})
         $display("FAIL b2b_second got %h exp %h", {out_valid, out_prd, out_prs1, out_prs2, out_prd_old},
                  {ev, e_prd, e_prs1, e_prs2, e_old});
      else passes++;
   endtask

   task automatic test_random();
      logic [1:0] v, w, ci, ri;
      logic [1:0][4:0] a, b, d;
      int ns;
      for (int it = 0; it < 80; it++) begin
         v = 2'($urandom_range(1, 3));
         w = 2'($urandom);
         for (int i = 0; i < 2; i++) begin
            a[i] = 5'($urandom_range(0, 7));
            b[i] = 5'($urandom_range(0, 7));
            d[i] = 5'($urandom_range(0, 7));
         end
         ci = 2'($urandom);
         put(v, w, a, b, d, 1'($urandom), ci);
         #1;
         checks++;
         if ({in_ready, prf_req} !== {1'b1, req}) $display("FAIL rnd%0d_req got %b exp %b", it, {in_ready, prf_req}, {1'b1, req});
         else passes++;
         tick();
         idle();
         ns = (req != 2'b00) ? $urandom_range(0, 2) : 0;
         for (int s = 0; s < ns; s++) begin
            allocatable = 1'b0;
            #1;
            checks++;
            if ({in_ready, prf_req} !== {1'b0, req}) $display("FAIL rnd%0d_stall got %b exp %b", it, {in_ready, prf_req}, {1'b0, req});
            else passes++;
            tick();
         end
         allocatable = (req != 2'b00) ? 1'b1 : 1'($urandom);
         prf_out = {6'($urandom_range(1, 63)), 6'($urandom_range(1, 63))};
         model(prf_out);
         tick();
         checks++;
         if ({out_valid, out_prd} !== {ev, e_prd}) $display("FAIL rnd%0d_prd got %h exp %h", it, {out_valid, out_prd}, {ev, e_prd});
         else passes++;
         for (int i = 0; i < 2; i++) if (ev[i]) begin
            checks++;
            if ({out_prs1[i], out_prs2[i], out_prd_old[i]} !== {e_prs1[i], e_prs2[i], e_old[i]})
               $display("FAIL rnd%0d_slot%0d got %h exp %h", it, i, {out_prs1[i], out_prs2[i], out_prd_old[i]},
                        {e_prs1[i], e_prs2[i], e_old[i]});
            else passes++;
         end
         if ($urandom_range(0, 5) == 0) begin
            ri = 2'($urandom);
            recover = 1'b1;
            recover_idx = ri;
            in_valid = 2'($urandom);
            in_rd_valid = 2'b11;
            in_rd = {5'd9, 5'd8};
            model_recover(ri);
            #1;
            checks++;
            if ({in_ready, prf_req} !== 3'b000) $display("FAIL rnd%0d_rec got %b exp 000", it, {in_ready, prf_req});
            else passes++;
            tick();
            recover = 1'b0;
            idle();
         end
      end
   endtask

   task automatic test_reset_mid_retry();
      put(2'b01, 2'b01, '0, '0, {5'd0, 5'd3}, 1'b0, 2'd0);
      tick();
      idle();
      allocatable = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({in_ready, prf_req, out_valid} !== 5'b10000)
         $display("FAIL rstretry got %b exp 10000", {in_ready, prf_req, out_valid});
      else passes++;
      tick();
      reset = 1'b0;
      tick();
      run_group(2'b11, 2'b00, {5'd5, 5'd3}, {5'd2, 5'd12}, '0, 1'b0, 2'd0, '0);
      checks++;
      if ({out_prs1, out_prs2} !== 24'd0) $display("FAIL rstretry_map got %h exp 0", {out_prs1, out_prs2});
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_same_rd();
      test_x0();
      test_stall();
      test_checkpoint_recover();
      test_recover_drop();
      test_back_to_back();
      test_random();
      test_reset_mid_retry();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
